seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the onboard I/O board. It holds a 32-bit hex value with per-digit decimal points and cycles one digit at a time at a programmable rate. It drives active-low segment and digit-enable lines and applies new values only at frame boundaries, so a frame never shows a mix of old and new digits. The CPU/debug logic writes values through a load/ack handshake.

Parameters:
SCAN_DIV, 20000, clk cycles each digit is lit (>=2); 20000 @ 100 MHz gives 200 us/digit, 1.6 ms frame
NUM_DIG, 8, digit count (fixed at 8 for this board; index width 3)

Ports:
clk       in   1   system clock
rst_n     in   1   asynchronous active-low reset
load      in   1   request to update display contents (level sampled every cycle)
data_in   in   32  hex value; nibble k drives digit k (digit 0 = rightmost)
dp_in     in   8   decimal point per digit, 1 = lit
en_mask   in   8   per-digit enable, 1 = digit allowed to light (live, not latched)
an        out  8   digit select, active-low, at most one bit low
seg       out  8   {a,b,c,d,e,f,g,dp}, active-low
load_ack  out  1   one-cycle pulse: pending/bypassed load has been applied
frame_done out 1   one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst_n=0): an=8'hFF, seg=8'hFF, load_ack=0, frame_done=0; div_cnt=0, idx=7, disp/dp regs=0, pending=0.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps; tick = (div_cnt==SCAN_DIV-1). First tick occurs SCAN_DIV cycles after reset release.
- On tick: nidx = idx+1 mod 8; idx<=nidx. Boundary tick = tick with nidx==0.
- Load capture: load=1 on a non-boundary cycle -> pend_data<=data_in, pend_dp<=dp_in, pending<=1. A later load overwrites the buffer (last write wins); only one ack per frame.
- Boundary tick: if load=1 then disp<=data_in, dp<=dp_in (same-cycle bypass); else if pending then disp<=pend. pending<=0. load_ack=1 in the following cycle iff an update occurred. frame_done=1 in the following cycle unconditionally.
- Output registers are updated on tick from post-update contents: an<=~(8'b1<<nidx) if en_mask[nidx], else 8'hFF. seg<={enc(disp[4*nidx+:4]), ~dp[nidx]}, forced to 8'hFF when digit disabled. Output changes become visible the cycle after the tick.
- enc (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Between ticks, an/seg hold their values. Latency from load to first lit new digit: at most 8*SCAN_DIV+1 cycles.
- Reset asserted mid-frame: immediate return to reset values. Pending load is discarded and no ack is issued.

Optional Feature:
LEAD_ZERO_BLANK_EN: when defined, digits above the most significant non-zero nibble of disp show seg=8'hFF (digit 0 is never blanked; value 0 shows a single "0"). A set dp bit on a blanked digit still lights dp (seg=8'hFE). When undefined, all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset with SCAN_DIV=4: hold rst_n=0, toggle clk -> an=FF, seg=FF, acks 0. Release -> first change in the cycle after the 4th edge: an=FE, seg=03 (digit 0 = "0", dp off).
- Load 0x1234ABCD, dp_in=0x01 mid-frame -> no change until the boundary. Then load_ack pulses once; digit 0: an=FE, seg=0x84 (d with dp); digit 3: an=F7, seg=0x11.
- Two loads in one frame (0x11111111 then 0x22222222) -> a single ack; every digit shows "2" (seg=0x25).
- load held high exactly on the boundary tick with 0x0000000F -> applied in that frame (bypass), ack on the next cycle, digit 0 seg=0x71.
- en_mask=8'b1111_1110 -> during digit-0 slot an=FF and seg=FF; other digits unaffected.
- LEAD_ZERO_BLANK_EN defined, disp=0x00000305 -> digits 3..7 seg=FF, digit 2 seg=0x0D, digit 1 seg=0x03; disp=0 -> only digit 0 shows seg=0x03.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
//
// It holds a 32-bit hex value with per-digit decimal points and lights one digit at a time.
// Each digit stays lit for SCAN_DIV clocks. New contents are loaded only at a frame boundary,
// so one frame never mixes old and new digits. Writes use a load/ack handshake.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   request to update display contents (level, sampled every cycle)
//   data_in    in   hex value; nibble k drives digit k (digit 0 = rightmost)
//   dp_in      in   decimal point per digit, 1 = lit
//   en_mask    in   per-digit enable, 1 = digit may light (live, not latched)
//   an         out  digit select, active-low, at most one bit low
//   seg        out  {a,b,c,d,e,f,g,dp}, active-low
//   load_ack   out  one-cycle pulse: a pending or bypassed load has been applied
//   frame_done out  one-cycle pulse at each frame boundary
//
// Optional build macro:
//   LEAD_ZERO_BLANK_EN - blank the digits above the most significant non-zero nibble.
//                        Digit 0 is never blanked. A set dp bit still lights on a blanked digit.

module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 20000,  // clocks per digit, >= 2
    parameter int unsigned NUM_DIG  = 8       // must stay 8: index wraps as a 3-bit counter
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic [NUM_DIG-1:0]     en_mask,
    output logic [NUM_DIG-1:0]     an,
    output logic [7:0]             seg,
    output logic                   load_ack,
    output logic                   frame_done
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = $clog2(NUM_DIG);

    // abcdefg, active-low
    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // State registers
    logic [DivW-1:0]      div_cnt_q, div_cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [4*NUM_DIG-1:0] disp_q, disp_d;
    logic [NUM_DIG-1:0]   dp_q, dp_d;
    logic [4*NUM_DIG-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d;
    logic                 pending_q, pending_d;
    logic [NUM_DIG-1:0]   an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 ack_q, ack_d;
    logic                 fd_q, fd_d;

    logic            tick;
    logic            boundary;
    logic [IdxW-1:0] nidx;
    logic [3:0]      nib;
    logic            blank;

    assign tick     = (div_cnt_q == DivW'(SCAN_DIV - 1));
    assign nidx     = idx_q + IdxW'(1);
    assign boundary = tick && (nidx == '0);

    // Divider, scan index and the display/pending buffers.
    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + DivW'(1);
        idx_d       = tick ? nidx : idx_q;
        disp_d      = disp_q;
        dp_d        = dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        ack_d       = 1'b0;
        fd_d        = boundary;

        if (boundary) begin
            // A load present on the boundary itself bypasses the buffer.
            if (load) begin
                disp_d = data_in;
                dp_d   = dp_in;
                ack_d  = 1'b1;
            end else if (pending_q) begin
                disp_d = pend_data_q;
                dp_d   = pend_dp_q;
                ack_d  = 1'b1;
            end
            pending_d = 1'b0;
        end else if (load) begin
            // Last write within a frame wins.
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pending_d   = 1'b1;
        end
    end

    // The nibble shown next comes from the post-update contents, so a boundary load
    // is already visible on digit 0 of the new frame.
    assign nib = disp_d[{nidx, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
    logic [IdxW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIG; k++) begin
            if (disp_d[4*k +: 4] != 4'h0) begin
                msd = IdxW'(k);
            end
        end
    end

    assign blank = (nidx > msd);
`else
    assign blank = 1'b0;
`endif

    // Output registers: reloaded only on a tick, held otherwise.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick) begin
            if (en_mask[nidx]) begin
                an_d  = ~(NUM_DIG'(1) << nidx);
                seg_d = {(blank ? 7'h7F : seg_enc(nib)), ~dp_d[nidx]};
            end else begin
                an_d  = '1;
                seg_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            idx_q       <= IdxW'(NUM_DIG - 1);
            disp_q      <= '0;
            dp_q        <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
            an_q        <= '1;
            seg_q       <= 8'hFF;
            ack_q       <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            dp_q        <= dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            ack_q       <= ack_d;
            fd_q        <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign load_ack   = ack_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4 (one frame = 32 cycles).
// The reference model derives the tick position and the digit from the cycle count since
// reset release. Directed literal checks pin that model at chosen cycles.

module tb_seg_scan_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_mask = 8'hFF;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        load_ack;
    logic        frame_done;

    int n_err = 0;
    int n_chk = 0;

    seg_scan_ctrl #(
        .SCAN_DIV(SD),
        .NUM_DIG (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .en_mask   (en_mask),
        .an        (an),
        .seg       (seg),
        .load_ack  (load_ack),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model
    int          mcyc = 0;  // clock edges since reset release
    logic [31:0] m_disp = '0;
    logic [7:0]  m_dp = '0;
    logic [31:0] m_pdata = '0;
    logic [7:0]  m_pdp = '0;
    bit          m_pend = 1'b0;
    logic [7:0]  m_an = 8'hFF;
    logic [7:0]  m_seg = 8'hFF;
    logic        m_ack = 1'b0;
    logic        m_fd = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int          c;
        int          d;
        int          top;
        bit          tick;
        bit          bnd;
        bit          upd;
        logic [31:0] nd;
        logic [7:0]  ndp;
        logic [6:0]  g;
        if (!rst_n) begin
            mcyc    <= 0;
            m_disp  <= '0;
            m_dp    <= '0;
            m_pend  <= 1'b0;
            m_an    <= 8'hFF;
            m_seg   <= 8'hFF;
            m_ack   <= 1'b0;
            m_fd    <= 1'b0;
        end else begin
            c    = mcyc + 1;
            tick = (c % SD) == 0;
            d    = (c / SD + 7) % 8;
            bnd  = tick && (d == 0);
            nd   = m_disp;
            ndp  = m_dp;
            upd  = 1'b0;
            if (bnd) begin
                if (load) begin
                    nd = data_in; ndp = dp_in; upd = 1'b1;
                end else if (m_pend) begin
                    nd = m_pdata; ndp = m_pdp; upd = 1'b1;
                end
                m_pend <= 1'b0;
            end else if (load) begin
                m_pdata <= data_in;
                m_pdp   <= dp_in;
                m_pend  <= 1'b1;
            end
            if (tick) begin
                if (!en_mask[d]) begin
                    m_an  <= 8'hFF;
                    m_seg <= 8'hFF;
                end else begin
                    m_an <= 8'hFF ^ (8'h01 << d);
                    g = glyph(nd[4*d +: 4]);
`ifdef LEAD_ZERO_BLANK_EN
                    top = 0;
                    for (int k = 0; k < 8; k++) begin
                        if (((nd >> (4 * k)) & 32'hF) != 0) top = k;
                    end
                    if (d > top) g = 7'h7F;
`endif
                    m_seg <= {g, ~ndp[d]};
                end
            end
            m_ack  <= upd;
            m_fd   <= bnd;
            m_disp <= nd;
            m_dp   <= ndp;
            mcyc   <= c;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("an", an, m_an);
        chk("seg", seg, m_seg);
        chk("load_ack", {7'd0, load_ack}, {7'd0, m_ack});
        chk("frame_done", {7'd0, frame_done}, {7'd0, m_fd});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while (mcyc < c && guard < 2000) begin
            step(1);
            guard++;
        end
        n_chk++;
        if (mcyc != c) begin
            n_err++;
            $display("FAIL goto: reached cycle %0d, wanted %0d", mcyc, c);
        end
    endtask

    task automatic put(input logic l, input logic [31:0] d, input logic [7:0] p);
        load = l; data_in = d; dp_in = p;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset held
        step(3);
        chk("rst an", an, 8'hFF);
        chk("rst seg", seg, 8'hFF);
        chk("rst ack", {7'd0, load_ack}, 8'h00);
        chk("rst fd", {7'd0, frame_done}, 8'h00);
        rst_n = 1'b1;
        goto(3);
        chk("pre-tick an", an, 8'hFF);
        goto(4);
        chk("first an", an, 8'hFE);
        chk("first seg", seg, 8'h03);
        chk("first fd", {7'd0, frame_done}, 8'h01);

        // Mid-frame load waits for the boundary
        goto(9);  put(1'b1, 32'h1234ABCD, 8'h01);
        goto(10); put(1'b0, 32'h0, 8'h00);
        chk("hold an", an, 8'hFD);
        chk("hold seg", seg, 8'h03);
        goto(36);
        chk("load ack", {7'd0, load_ack}, 8'h01);
        chk("d0 an", an, 8'hFE);
        chk("d0 seg", seg, 8'h84);
        goto(37);
        chk("ack pulse", {7'd0, load_ack}, 8'h00);
        goto(48);
        chk("d3 an", an, 8'hF7);
        chk("d3 seg", seg, 8'h11);

        // Two loads in one frame: last wins, one ack
        goto(50); put(1'b1, 32'h11111111, 8'h00);
        goto(51); put(1'b0, 32'h0, 8'h00);
        goto(55); put(1'b1, 32'h22222222, 8'h00);
        goto(56); put(1'b0, 32'h0, 8'h00);
        goto(68);
        chk("2x ack", {7'd0, load_ack}, 8'h01);
        chk("2x seg", seg, 8'h25);
        goto(69);
        chk("2x ack once", {7'd0, load_ack}, 8'h00);
        goto(88);
        chk("2x d5 an", an, 8'hDF);
        chk("2x d5 seg", seg, 8'h25);

        // Load exactly on the boundary tick: bypass
        goto(99);  put(1'b1, 32'h0000000F, 8'h00);
        goto(100); put(1'b0, 32'h0, 8'h00);
        chk("byp ack", {7'd0, load_ack}, 8'h01);
        chk("byp an", an, 8'hFE);
        chk("byp seg", seg, 8'h71);
        goto(101);
        chk("byp ack once", {7'd0, load_ack}, 8'h00);

        // Digit 0 masked off
        en_mask = 8'hFE;
        goto(132);
        chk("mask an", an, 8'hFF);
        chk("mask seg", seg, 8'hFF);
        goto(136);
        chk("mask d1 an", an, 8'hFD);
        chk("mask d1 seg", seg, 8'h03);
        en_mask = 8'hFF;

        // Reset mid-frame discards the pending load
        goto(140); put(1'b1, 32'h55555555, 8'hFF);
        goto(141); put(1'b0, 32'h0, 8'h00);
        goto(145);
        rst_n = 1'b0;
        #1;
        chk("mid rst an", an, 8'hFF);
        chk("mid rst seg", seg, 8'hFF);
        step(2);
        rst_n = 1'b1;
        goto(4);
        chk("post rst ack", {7'd0, load_ack}, 8'h00);
        chk("post rst seg", seg, 8'h03);
        chk("post rst an", an, 8'hFE);

        // Leading-zero handling with 0x305, dp on digit 7
        goto(10); put(1'b1, 32'h00000305, 8'h80);
        goto(11); put(1'b0, 32'h0, 8'h00);
        goto(36);
        chk("305 ack", {7'd0, load_ack}, 8'h01);
        chk("305 d0", seg, 8'h49);
        goto(40);
        chk("305 d1", seg, 8'h03);
        goto(44);
        chk("305 d2", seg, 8'h0D);
        goto(48);
`ifdef LEAD_ZERO_BLANK_EN
        chk("305 d3", seg, 8'hFF);
`else
        chk("305 d3", seg, 8'h03);
`endif
        goto(64);
        chk("305 d7 an", an, 8'h7F);
`ifdef LEAD_ZERO_BLANK_EN
        chk("305 d7 seg", seg, 8'hFE);
`else
        chk("305 d7 seg", seg, 8'h02);
`endif
        goto(66); put(1'b1, 32'h0, 8'h00);
        goto(67); put(1'b0, 32'h0, 8'h00);
        goto(68);
        chk("zero d0", seg, 8'h03);
        goto(72);
`ifdef LEAD_ZERO_BLANK_EN
        chk("zero d1", seg, 8'hFF);
`else
        chk("zero d1", seg, 8'h03);
`endif
        step(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
